// File: rtl/tetris_pkg.sv
// Shared playfield definitions for game logic, board store and renderer.
//   COLS/ROWS      playfield size in cells
//   X_W/Y_W        coordinate widths
//   clear_state_t  line-clear FSM states
//   WALL_RDATA     collision value returned outside the playfield
//   VGA_OOR_CELL   renderer value returned outside the playfield
package tetris_pkg;

    localparam int unsigned COLS = 10;
    localparam int unsigned ROWS = 20;
    localparam int unsigned X_W  = 4;
    localparam int unsigned Y_W  = 5;

    localparam logic [2:0] LINES_MAX = 3'd4;

    // Out-of-range collision reads look like solid wall; the renderer draws nothing there.
    localparam logic WALL_RDATA   = 1'b1;
    localparam logic VGA_OOR_CELL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SHIFT,
        ST_DONE
    } clear_state_t;

    function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (32'(x) < COLS) && (32'(y) < ROWS);
    endfunction

endpackage

// File: rtl/tetris_clear_fsm.sv
// Line-clear sequencer: walks rows bottom-up, requests a shift for every full row.
//   CLOCK_50, resetn   clock, synchronous active-low reset
//   board_clear        new-game wipe; aborts any sweep
//   clear_start        pulse to start a sweep (ignored while busy)
//   row_full           top reports whether row row_sel is all ones
//   row_sel            row currently under inspection
//   shift_en           one-cycle strobe: move rows 0..row_sel-1 down by one
//   clear_busy         sweep in progress
//   clear_done         one-cycle pulse at sweep end
//   lines_cleared      rows removed by the last sweep (saturates at 4)
//   total_lines        rows removed since reset/board_clear (saturating)
module tetris_clear_fsm
    import tetris_pkg::*;
#(
    parameter int unsigned TOTAL_W = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               board_clear,
    input  logic               clear_start,
    input  logic               row_full,
    output logic [Y_W-1:0]     row_sel,
    output logic               shift_en,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [2:0]         lines_cleared,
    output logic [TOTAL_W-1:0] total_lines
);

    clear_state_t       state_q, state_d;
    logic [Y_W-1:0]     r_q, r_d;
    logic [2:0]         lines_q, lines_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn || board_clear) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            lines_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            lines_q <= lines_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        lines_d  = lines_q;
        total_d  = total_q;
        shift_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_SCAN;
                    r_d     = Y_W'(ROWS - 1);
                    lines_d = '0;
                end
            end
            ST_SCAN: begin
                if (row_full) begin
                    state_d = ST_SHIFT;
                end else if (r_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    r_d = r_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                // r is held so the row that just dropped into it gets re-checked.
                shift_en = 1'b1;
                lines_d  = (lines_q == LINES_MAX) ? lines_q : lines_q + 3'd1;
                total_d  = (total_q == '1) ? total_q : total_q + 1'b1;
                state_d  = ST_SCAN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign row_sel       = r_q;
    assign clear_busy    = (state_q != ST_IDLE);
    assign clear_done    = (state_q == ST_DONE);
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

endmodule

// File: rtl/tetris_board_store.sv
// Playfield occupancy store with collision/VGA read ports and line-clear engine.
//   CLOCK_50, resetn          clock, synchronous active-low reset
//   board_we/wx/wy/wdata      single-cell write from game logic (IDLE only)
//   board_rx/ry -> board_rdata  combinational collision read (wall outside field)
//   vga_cx/cy -> vga_cell       combinational renderer read (empty outside field)
//   board_clear               wipe board and counters, abort sweep
//   clear_start               start a line-clear sweep
//   clear_busy, clear_done    sweep status
//   lines_cleared, total_lines  sweep results
//   write_drop                sticky flag: a write was discarded during a sweep
module tetris_board_store
    import tetris_pkg::*;
#(
    parameter int unsigned TOTAL_W = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               board_we,
    input  logic [X_W-1:0]     board_wx,
    input  logic [Y_W-1:0]     board_wy,
    input  logic               board_wdata,
    input  logic [X_W-1:0]     board_rx,
    input  logic [Y_W-1:0]     board_ry,
    output logic               board_rdata,
    input  logic [X_W-1:0]     vga_cx,
    input  logic [Y_W-1:0]     vga_cy,
    output logic               vga_cell,
    input  logic               board_clear,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [2:0]         lines_cleared,
    output logic [TOTAL_W-1:0] total_lines,
    output logic               write_drop
);

    logic [COLS-1:0] row_q [ROWS];
    logic [Y_W-1:0]  row_sel;
    logic            shift_en;
    logic            row_full;

    assign row_full = &row_q[row_sel];

    tetris_clear_fsm #(
        .TOTAL_W(TOTAL_W)
    ) u_clear_fsm (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .board_clear   (board_clear),
        .clear_start   (clear_start),
        .row_full      (row_full),
        .row_sel       (row_sel),
        .shift_en      (shift_en),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn || board_clear) begin
            for (int unsigned k = 0; k < ROWS; k++) begin
                row_q[k] <= '0;
            end
            write_drop <= 1'b0;
        end else begin
            if (shift_en) begin
                for (int unsigned k = 1; k < ROWS; k++) begin
                    if (k <= 32'(row_sel)) begin
                        row_q[k] <= row_q[k-1];
                    end
                end
                row_q[0] <= '0;
            end else if (board_we && !clear_busy && in_range(board_wx, board_wy)) begin
                row_q[board_wy][board_wx] <= board_wdata;
            end
            if (board_we && clear_busy) begin
                write_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        board_rdata = WALL_RDATA;
        if (in_range(board_rx, board_ry)) begin
            board_rdata = row_q[board_ry][board_rx];
        end
    end

    always_comb begin
        vga_cell = VGA_OOR_CELL;
        if (in_range(vga_cx, vga_cy)) begin
            vga_cell = row_q[vga_cy][vga_cx];
        end
    end

endmodule
